airlock_timer: RTL

//  Upstream timing stage for the airlock interlock FSMs (entering/leaving).

---
 rtl/airlock_timer_pkg.sv | 22 ++
 rtl/airlock_timer_tick_prescaler.sv | 37 +++
 rtl/airlock_timer.sv | 117 +++++++++++
 3 files changed

// File: rtl/airlock_timer_pkg.sv
// Shared airlock types and constants: FSM states, chamber op codes and second thresholds.
// Imported by the timer and by the entering/leaving interlock FSMs.
package airlock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_DOOR  = 2'd0,
    OP_PRESS = 2'd1,
    OP_EVAC  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  localparam logic [3:0] FIVE_SEC  = 4'd5;
  localparam logic [3:0] SEVEN_SEC = 4'd7;
  localparam logic [3:0] EIGHT_SEC = 4'd8;

endpackage

// File: rtl/airlock_timer_tick_prescaler.sv
// Clock-cycle prescaler: counts enabled cycles and flags the last cycle of each second.
// tick is high in the enabled cycle where the counter wraps back to zero.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 390625
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/airlock_timer.sv
// Airlock operation timer: times one door/pressurize/evacuate op per start, with abort.
// Optional pause input when AIRLOCK_TIMER_PAUSE_EN is defined.
module airlock_timer
  import airlock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 390625,
  parameter int DOOR_SEC      = 5,
  parameter int PRESS_SEC     = 7,
  parameter int EVAC_SEC      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       abort,
`ifdef AIRLOCK_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       sec_tick,
  output logic [3:0] seconds,
  output logic [2:0] sec_flags
);

  state_e     state_q;
  op_e        op_q;
  logic [3:0] seconds_q;
  logic       busy_q, done_q, aborted_q, sec_tick_q;

  logic       paused, in_run, take_abort, accept, at_target, presc_en, tick;
  logic [3:0] target;

`ifdef AIRLOCK_TIMER_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Abort outranks start; a reserved op code never counts as a start.
  assign in_run     = (state_q == RUN);
  assign take_abort = in_run && abort;
  assign accept     = start && (op != OP_RSVD) && !take_abort;

  always_comb begin
    target = 4'(DOOR_SEC);
    case (op_q)
      OP_PRESS: target = 4'(PRESS_SEC);
      OP_EVAC:  target = 4'(EVAC_SEC);
      default:  target = 4'(DOOR_SEC);
    endcase
  end

  assign at_target = (seconds_q == target);
  assign presc_en  = in_run && !paused && !at_target && !accept && !take_abort;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .enable(presc_en),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= OP_DOOR;
      seconds_q  <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      if (take_abort) begin
        state_q   <= IDLE;
        seconds_q <= 4'd0;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else if (accept) begin
        state_q   <= RUN;
        op_q      <= op_e'(op);
        seconds_q <= 4'd0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (at_target) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (tick) begin
              seconds_q  <= (seconds_q == 4'hF) ? seconds_q : seconds_q + 4'd1;
              sec_tick_q <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign sec_tick  = sec_tick_q;
  assign seconds   = seconds_q;
  assign sec_flags = {seconds_q == EIGHT_SEC, seconds_q == SEVEN_SEC, seconds_q == FIVE_SEC};

endmodule
